czono_loader: RTL

// Upstream stage for the constrained-zonotope operators (plus, linear_image, intersection).
// - Accepts one CZonotope as a stream of DATA_WIDTH-bit IEEE-754 words over a valid/ready handshake.
// - Fills the driven CZonotope interface: n, ng, nc, c, G, A, b.
// - Pulses done_o when the set is complete and consistent. Operators sample Z only after done_o.

---
 rtl/czono_loader_if.sv | 19 +
 rtl/czono_loader.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/czono_loader_if.sv
// Constrained-zonotope container (n, ng, nc, c, G, A, b) shared by the loader
// and the downstream set operators.
interface CZonotope #(
  parameter int DATA_WIDTH = 32,
  parameter int NMAX       = 10,
  parameter int NGMAX      = 5,
  parameter int NCMAX      = 3
);
  logic [7:0]            n;
  logic [7:0]            ng;
  logic [7:0]            nc;
  logic [DATA_WIDTH-1:0] c [NMAX];
  logic [DATA_WIDTH-1:0] G [NMAX][NGMAX];
  logic [DATA_WIDTH-1:0] A [NCMAX][NGMAX];
  logic [DATA_WIDTH-1:0] b [NCMAX];

  modport drv (output n, ng, nc, c, G, A, b);
  modport snk (input  n, ng, nc, c, G, A, b);
endinterface

// File: rtl/czono_loader.sv
// Streams one constrained zonotope (header, c, G, A, b) into a CZonotope interface.
// Define CZONO_LOADER_CHECKSUM_EN to require an XOR trailer word after the set.
module czono_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int NMAX       = 10,
  parameter int NGMAX      = 5,
  parameter int NCMAX      = 3
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_last_i,
  CZonotope.drv                 Z,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);
`ifdef CZONO_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif
  localparam int NW = (NMAX > 1)  ? $clog2(NMAX)  : 1;
  localparam int GW = (NGMAX > 1) ? $clog2(NGMAX) : 1;
  localparam int CW = (NCMAX > 1) ? $clog2(NCMAX) : 1;

  typedef enum logic [2:0] {IDLE, LOAD_C, LOAD_G, LOAD_A, LOAD_B, CHK, DONE, ERR_DRAIN} state_t;

  state_t                state_q, phase_next;
  logic [7:0]            lat_n, lat_ng, lat_nc, row_q, col_q;
  logic [7:0]            hdr_n, hdr_ng, hdr_nc;
  logic [DATA_WIDTH-1:0] csum_q;
  logic                  xfer, hdr_bad, row_end, col_end, phase_end, is_final, word_bad;

  assign xfer    = s_valid_i && s_ready_o;
  assign hdr_n   = s_data_i[7:0];
  assign hdr_ng  = s_data_i[15:8];
  assign hdr_nc  = s_data_i[23:16];
  assign hdr_bad = (hdr_n == 8'd0) || (int'(hdr_n) > NMAX) || (hdr_ng == 8'd0) ||
                   (int'(hdr_ng) > NGMAX) || (int'(hdr_nc) > NCMAX);

  // Phase bookkeeping: is the current word the last of its section, and where next.
  always_comb begin
    col_end    = (col_q == lat_ng - 8'd1);
    row_end    = 1'b0;
    phase_end  = 1'b0;
    phase_next = state_q;
    case (state_q)
      LOAD_C: begin
        row_end    = (row_q == lat_n - 8'd1);
        phase_end  = row_end;
        phase_next = LOAD_G;
      end
      LOAD_G: begin
        row_end    = (row_q == lat_n - 8'd1);
        phase_end  = row_end && col_end;
        phase_next = (lat_nc == 8'd0) ? (CSUM_EN ? CHK : DONE) : LOAD_A;
      end
      LOAD_A: begin
        row_end    = (row_q == lat_nc - 8'd1);
        phase_end  = row_end && col_end;
        phase_next = LOAD_B;
      end
      LOAD_B: begin
        row_end    = (row_q == lat_nc - 8'd1);
        phase_end  = row_end;
        phase_next = CSUM_EN ? CHK : DONE;
      end
      CHK: begin
        phase_end  = 1'b1;
        phase_next = DONE;
      end
      default: ;
    endcase
    is_final = phase_end && (phase_next == DONE);
    word_bad = (s_last_i != is_final) || ((state_q == CHK) && (s_data_i != csum_q));
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      s_ready_o <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      lat_n     <= '0;
      lat_ng    <= '0;
      lat_nc    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      csum_q    <= '0;
      Z.n       <= '0;
      Z.ng      <= '0;
      Z.nc      <= '0;
      for (int i = 0; i < NMAX; i++) begin
        Z.c[i] <= '0;
        for (int j = 0; j < NGMAX; j++) Z.G[i][j] <= '0;
      end
      for (int i = 0; i < NCMAX; i++) begin
        Z.b[i] <= '0;
        for (int j = 0; j < NGMAX; j++) Z.A[i][j] <= '0;
      end
    end else begin
      done_o    <= 1'b0;
      s_ready_o <= 1'b1;
      case (state_q)
        IDLE: if (xfer) begin
          // Unused slots must read zero for the downstream operators.
          for (int i = 0; i < NMAX; i++) begin
            Z.c[i] <= '0;
            for (int j = 0; j < NGMAX; j++) Z.G[i][j] <= '0;
          end
          for (int i = 0; i < NCMAX; i++) begin
            Z.b[i] <= '0;
            for (int j = 0; j < NGMAX; j++) Z.A[i][j] <= '0;
          end
          Z.n    <= '0;
          Z.ng   <= '0;
          Z.nc   <= '0;
          lat_n  <= hdr_n;
          lat_ng <= hdr_ng;
          lat_nc <= hdr_nc;
          row_q  <= '0;
          col_q  <= '0;
          csum_q <= s_data_i;
          if (hdr_bad || s_last_i) begin
            err_o   <= 1'b1;
            busy_o  <= 1'b0;
            state_q <= s_last_i ? IDLE : ERR_DRAIN;
          end else begin
            err_o   <= 1'b0;
            busy_o  <= 1'b1;
            state_q <= LOAD_C;
          end
        end
        LOAD_C, LOAD_G, LOAD_A, LOAD_B, CHK: if (xfer) begin
          csum_q <= csum_q ^ s_data_i;
          case (state_q)
            LOAD_C:  Z.c[NW'(row_q)]             <= s_data_i;
            LOAD_G:  Z.G[NW'(row_q)][GW'(col_q)] <= s_data_i;
            LOAD_A:  Z.A[CW'(row_q)][GW'(col_q)] <= s_data_i;
            LOAD_B:  Z.b[CW'(row_q)]             <= s_data_i;
            default: ;
          endcase
          if (word_bad) begin
            err_o   <= 1'b1;
            busy_o  <= 1'b0;
            state_q <= s_last_i ? IDLE : ERR_DRAIN;
          end else if (is_final) begin
            state_q   <= DONE;
            done_o    <= 1'b1;
            busy_o    <= 1'b0;
            s_ready_o <= 1'b0;
            Z.n       <= lat_n;
            Z.ng      <= lat_ng;
            Z.nc      <= lat_nc;
          end else if (phase_end) begin
            state_q <= phase_next;
            row_q   <= '0;
            col_q   <= '0;
          end else if (((state_q == LOAD_G) || (state_q == LOAD_A)) && !col_end) begin
            col_q <= col_q + 8'd1;
          end else begin
            col_q <= '0;
            row_q <= row_q + 8'd1;
          end
        end
        DONE:      state_q <= IDLE;
        ERR_DRAIN: if (xfer && s_last_i) state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

endmodule
